// File: rtl/tt_scan_ctrl.sv
// Scan-chain master for tt_dpll: shifts a host pattern into the DPLL chain, runs N
// functional capture cycles, unloads the chain and returns the word over valid/ready.
module tt_scan_ctrl #(
  parameter int CHAIN_LEN = 37,
  parameter int CAP_W     = 8
) (
  input  logic                 i_clk_gen,
  input  logic                 i_rst,
  input  logic                 i_start_valid,
  output logic                 o_start_ready,
  input  logic [CHAIN_LEN-1:0] i_pattern,
  input  logic [CAP_W-1:0]     i_capture_cycles,
  output logic                 o_scan_en,
  output logic                 o_scan_in,
  input  logic                 i_scan_out,
  output logic                 o_result_valid,
  input  logic                 i_result_ready,
  output logic [CHAIN_LEN-1:0] o_result,
  output logic                 o_busy
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] result_q, result_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CAP_W-1:0]     cap_cnt_q, cap_cnt_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 result_valid_q, result_valid_d;

  // Outputs are computed one cycle ahead so scan_en/scan_in/result_valid leave flops directly.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    state_d        = state_q;
    pat_d          = pat_q;
    result_d       = result_q;
    bit_cnt_d      = bit_cnt_q;
    cap_cnt_d      = cap_cnt_q;
    scan_en_d      = scan_en_q;
    scan_in_d      = scan_in_q;
    result_valid_d = result_valid_q;

    case (state_q)
      S_IDLE: begin
        if (i_start_valid) begin
          state_d   = S_SHIFT;
          pat_d     = i_pattern >> 1;
          cap_cnt_d = i_capture_cycles;
          bit_cnt_d = LAST_BIT;
          scan_en_d = 1'b1;
          scan_in_d = i_pattern[0];
          result_d  = '0;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - BW'(1);
          scan_in_d = pat_q[0];
          pat_d     = pat_q >> 1;
        end else if (cap_cnt_q != '0) begin
          state_d   = S_CAPTURE;
          cap_cnt_d = cap_cnt_q - CAP_W'(1);
          scan_en_d = 1'b0;
          scan_in_d = 1'b0;
        end else begin
          // Zero capture cycles: go straight to unload with scan_en held high.
          state_d   = S_UNLOAD;
          bit_cnt_d = LAST_BIT;
          scan_in_d = 1'b0;
        end
      end

      S_CAPTURE: begin
        if (cap_cnt_q != '0) begin
          cap_cnt_d = cap_cnt_q - CAP_W'(1);
        end else begin
          state_d   = S_UNLOAD;
          bit_cnt_d = LAST_BIT;
          scan_en_d = 1'b1;
        end
      end

      S_UNLOAD: begin
        // First sampled bit drifts down to result[0] after CHAIN_LEN samples.
        result_d = {i_scan_out, result_q[CHAIN_LEN-1:1]};
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - BW'(1);
        end else begin
          state_d        = S_DONE;
          scan_en_d      = 1'b0;
          result_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        if (i_result_ready) begin
          state_d        = S_IDLE;
          result_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_gen) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (i_rst) begin
      state_q        <= S_IDLE;
      result_q       <= '0;
      bit_cnt_q      <= '0;
      cap_cnt_q      <= '0;
      scan_en_q      <= 1'b0;
      scan_in_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      bit_cnt_q      <= bit_cnt_d;
      cap_cnt_q      <= cap_cnt_d;
      scan_en_q      <= scan_en_d;
      scan_in_q      <= scan_in_d;
      result_valid_q <= result_valid_d;
    end
  end

  // NOTE: the pattern holding register is pure datapath, always loaded before use, so it has no reset.
  always_ff @(posedge i_clk_gen) begin
    pat_q <= pat_d;
  end

  assign o_scan_en      = scan_en_q;
  assign o_scan_in      = scan_in_q;
  assign o_result_valid = result_valid_q;
  assign o_result       = result_q;
  assign o_start_ready  = (state_q == S_IDLE);
  assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Directed bench for tt_scan_ctrl: two DUTs (37-flop and 2-flop chains), each driving a
// behavioural scan-chain model whose last flop (index 0) feeds back into scan_out.
module tb_tt_scan_ctrl;

  localparam int L  = 37;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_valid, start_ready;
  logic [L-1:0]  pattern;
  logic [CW-1:0] cap;
  logic          scan_en, scan_in, scan_out;
  logic          result_valid, result_ready;
  logic [L-1:0]  result;
  logic          busy;

  logic          s_start_valid, s_start_ready;
  logic [1:0]    s_pattern;
  logic [1:0]    s_cap;
  logic          s_scan_en, s_scan_in, s_scan_out;
  logic          s_result_valid, s_result_ready;
  logic [1:0]    s_result;
  logic          s_busy;

  int total = 0;
  int bad   = 0;

  tt_scan_ctrl #(.CHAIN_LEN(L), .CAP_W(CW)) dut (
    .i_clk_gen        (clk),
    .i_rst            (rst),
    .i_start_valid    (start_valid),
    .o_start_ready    (start_ready),
    .i_pattern        (pattern),
    .i_capture_cycles (cap),
    .o_scan_en        (scan_en),
    .o_scan_in        (scan_in),
    .i_scan_out       (scan_out),
    .o_result_valid   (result_valid),
    .i_result_ready   (result_ready),
    .o_result         (result),
    .o_busy           (busy)
  );

  tt_scan_ctrl #(.CHAIN_LEN(2), .CAP_W(2)) dut_small (
    .i_clk_gen        (clk),
    .i_rst            (rst),
    .i_start_valid    (s_start_valid),
    .o_start_ready    (s_start_ready),
    .i_pattern        (s_pattern),
    .i_capture_cycles (s_cap),
    .o_scan_en        (s_scan_en),
    .o_scan_in        (s_scan_in),
    .i_scan_out       (s_scan_out),
    .o_result_valid   (s_result_valid),
    .i_result_ready   (s_result_ready),
    .o_result         (s_result),
    .o_busy           (s_busy)
  );

  // Chain models: chain[0] is the flop nearest scan_out.
  logic [L-1:0] chain   = '0;
  logic         mode_load = 1'b0;
  logic [1:0]   s_chain = '0;

  assign scan_out   = chain[0];
  assign s_scan_out = s_chain[0];

  always @(posedge clk) begin
    if (scan_en) chain <= {scan_in, chain[L-1:1]};
    else if (mode_load) chain <= 37'h0_F0F0_F0F0;
  end

  always @(posedge clk) begin
    if (s_scan_en) s_chain <= {s_scan_in, s_chain[1]};
    else s_chain <= ~s_chain;
  end

  logic en_tr [0:511];

  // Issue a start at the current negedge and record scan_en per cycle until result_valid.
  task automatic run_big(input logic [L-1:0] pat, input logic [CW-1:0] c, output int lat);
    start_valid = 1'b1;
    pattern     = pat;
    cap         = c;
    lat         = -1;
    for (int n = 1; n < 512; n++) begin
      @(negedge clk);
      start_valid = 1'b0;
      en_tr[n]    = scan_en;
      if (result_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic accept_big();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (scan_en !== 1'b0) begin bad++; $display("FAIL reset_scan_en: got %b want 0", scan_en); end
    total++; if (scan_in !== 1'b0) begin bad++; $display("FAIL reset_scan_in: got %b want 0", scan_in); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", start_ready); end
    total++; if (s_scan_en !== 1'b0 || s_start_ready !== 1'b1) begin
      bad++; $display("FAIL reset_small: en=%b ready=%b want 0/1", s_scan_en, s_start_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    int lat, hi, first_lo, last;
    logic [L-1:0] pat;
    pat = 37'h1_2345_6789;
    mode_load = 1'b0;
    run_big(pat, 8'd0, lat);
    total++; if (lat !== 75) begin bad++; $display("FAIL loop_latency: got %0d want 75", lat); end
    total++; if (result !== pat) begin bad++; $display("FAIL loop_result: got %h want %h", result, pat); end
    hi = 0; first_lo = -1;
    last = (lat > 0) ? lat : 511;
    for (int n = 1; n <= last; n++) begin
      if (en_tr[n] === 1'b1) hi++;
      else if (first_lo < 0) first_lo = n;
    end
    total++; if (hi !== 74) begin bad++; $display("FAIL loop_en_count: got %0d want 74", hi); end
    total++; if (first_lo !== 75) begin bad++; $display("FAIL loop_en_gap: first low cycle %0d want 75", first_lo); end
    accept_big();
    total++; if (start_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL loop_accept: ready=%b busy=%b valid=%b want 1/0/0", start_ready, busy, result_valid);
    end
  endtask

  task automatic test_capture();
    int lat, lo, first_lo, last;
    mode_load = 1'b1;
    run_big(37'h0_1234_5678, 8'd3, lat);
    total++; if (result !== 37'h0_F0F0_F0F0) begin bad++; $display("FAIL cap_result: got %h want 0f0f0f0f0", result); end
    total++; if (lat !== 78) begin bad++; $display("FAIL cap_latency: got %0d want 78", lat); end
    lo = 0; first_lo = -1;
    last = (lat > 0) ? lat - 1 : 511;
    for (int n = 1; n <= last; n++) begin
      if (en_tr[n] !== 1'b1) begin
        lo++;
        if (first_lo < 0) first_lo = n;
      end
    end
    total++; if (lo !== 3) begin bad++; $display("FAIL cap_gap_len: got %0d want 3", lo); end
    total++; if (first_lo !== 38) begin bad++; $display("FAIL cap_gap_start: got %0d want 38", first_lo); end
    accept_big();
    mode_load = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [L-1:0] pat;
    pat = 37'h0A_5A5A_5A5A;
    run_big(pat, 8'd2, lat);
    total++; if (lat !== 77) begin bad++; $display("FAIL bp_latency: got %0d want 77", lat); end
    start_valid = 1'b1;
    pattern     = 37'h15_0000_FFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, result_valid); end
      total++; if (result !== pat) begin bad++; $display("FAIL bp_result[%0d]: got %h want %h", i, result, pat); end
      total++; if (start_ready !== 1'b0 || scan_en !== 1'b0) begin
        bad++; $display("FAIL bp_idle[%0d]: ready=%b scan_en=%b want 0/0", i, start_ready, scan_en);
      end
    end
    start_valid = 1'b0;
    accept_big();
    total++; if (start_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: ready=%b busy=%b valid=%b want 1/0/0", start_ready, busy, result_valid);
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || scan_en !== 1'b0) begin
      bad++; $display("FAIL bp_no_queue: busy=%b scan_en=%b want 0/0", busy, scan_en);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, seen;
    logic [L-1:0] pat;
    start_valid = 1'b1;
    pattern     = 37'h1F_FFFF_FFFF;
    cap         = 8'd0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      start_valid = 1'b0;
    end
    total++; if (scan_en !== 1'b1) begin bad++; $display("FAIL rst_mid_in_shift: scan_en=%b want 1", scan_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (scan_en !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid: scan_en=%b busy=%b valid=%b want 0/0/0", scan_en, busy, result_valid);
    end
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", seen); end
    pat = 37'h0C_3C3C_A5A5;
    run_big(pat, 8'd0, lat);
    total++; if (result !== pat || lat !== 75) begin
      bad++; $display("FAIL rst_mid_fresh: result=%h lat=%0d want %h/75", result, lat, pat);
    end
    accept_big();
  endtask

  task automatic test_boundary();
    int lat, err;
    logic exp_en;
    logic s_tr [0:63];
    s_start_valid = 1'b1;
    s_pattern     = 2'b10;
    s_cap         = 2'd3;
    lat = -1;
    for (int n = 1; n < 64; n++) begin
      @(negedge clk);
      s_start_valid = 1'b0;
      s_tr[n] = s_scan_en;
      if (s_result_valid) begin
        lat = n;
        break;
      end
    end
    total++; if (s_result !== 2'b01) begin bad++; $display("FAIL small_result: got %b want 01", s_result); end
    total++; if (lat !== 8) begin bad++; $display("FAIL small_latency: got %0d want 8", lat); end
    err = 0;
    for (int n = 1; n <= 7; n++) begin
      exp_en = (n <= 2 || n >= 6);
      if (s_tr[n] !== exp_en) err++;
    end
    total++; if (err !== 0) begin bad++; $display("FAIL small_en_trace: got %0d wrong cycles want 0", err); end
    s_result_ready = 1'b1;
    @(negedge clk);
    s_result_ready = 1'b0;
    total++; if (s_start_ready !== 1'b1 || s_result_valid !== 1'b0) begin
      bad++; $display("FAIL small_accept: ready=%b valid=%b want 1/0", s_start_ready, s_result_valid);
    end
  endtask

  initial begin
    rst            = 1'b1;
    start_valid    = 1'b0;
    pattern        = '0;
    cap            = '0;
    result_ready   = 1'b0;
    s_start_valid  = 1'b0;
    s_pattern      = '0;
    s_cap          = '0;
    s_result_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_capture();
    test_backpressure();
    test_reset_mid_shift();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
